// File: rtl/tag_inv_pkg.sv
`default_nettype none
// ============================================================================
// tag_inv_pkg : tag state, reply-type and command-bit encodings for tag_inv_ctrl
// Rev 1.0
// ============================================================================
package tag_inv_pkg;

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_ARB   = 3'd1,
    ST_REPLY = 3'd2,
    ST_ACK   = 3'd3,
    ST_OPEN  = 3'd4
  } inv_state_e;

  typedef enum logic [2:0] {
    TX_NONE    = 3'd0,
    TX_RN16    = 3'd1,
    TX_EPC     = 3'd2,
    TX_HANDLE  = 3'd3,
    TX_CMDRESP = 3'd4
  } tx_sel_e;

  typedef enum logic [2:0] {
    SLOT_HOLD = 3'd0,
    SLOT_LOAD = 3'd1,
    SLOT_DEC  = 3'd2,
    SLOT_MAX  = 3'd3,
    SLOT_CLR  = 3'd4
  } slot_op_e;

  localparam int C_CMD_QUERYREP = 0;
  localparam int C_CMD_ACK      = 1;
  localparam int C_CMD_QUERY    = 2;
  localparam int C_CMD_QUERYADJ = 3;
  localparam int C_CMD_SELECT   = 4;
  localparam int C_CMD_NACK     = 5;
  localparam int C_CMD_REQRN    = 6;
  localparam int C_CMD_READ     = 7;
  localparam int C_CMD_WRITE    = 8;
  localparam int C_CMD_CUSTOM11 = 11;

  // UpDn: 2'b11 steps up, 2'b01 steps down, anything else holds; clamps at 0 and 15
  function automatic logic [3:0] q_adjust(input logic [3:0] q, input logic [1:0] updn);
    q_adjust = q;
    if (updn == 2'b11 && q != 4'd15) q_adjust = q + 4'd1;
    else if (updn == 2'b01 && q != 4'd0) q_adjust = q - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_inv_ctrl_if.sv
`default_nettype none
// ============================================================================
// tag_inv_ctrl_if : parser-side inputs and tx-side outputs of tag_inv_ctrl
// Rev 1.0
// ============================================================================
interface tag_inv_ctrl_if #(
  parameter int CMD_W  = 13,
  parameter int SLOT_W = 15
);
  logic [CMD_W-1:0]  cmd_in;
  logic              packet_done;
  logic              crc5_bad;
  logic              crc16_bad;
  logic [3:0]        q_query;
  logic [1:0]        q_adj;
  logic [15:0]       rn_in;
  logic              rn_match;
  logic              tx_busy;
  logic [2:0]        inv_state;
  logic              tx_start;
  logic [2:0]        tx_sel;
  logic [CMD_W-1:0]  resp_cmd;
  logic [15:0]       rn16;
  logic [SLOT_W-1:0] slot;
  logic [3:0]        q_cur;
  logic              cmd_drop;

  modport master (
    output cmd_in, packet_done, crc5_bad, crc16_bad, q_query, q_adj, rn_in, rn_match, tx_busy,
    input  inv_state, tx_start, tx_sel, resp_cmd, rn16, slot, q_cur, cmd_drop
  );

  modport slave (
    input  cmd_in, packet_done, crc5_bad, crc16_bad, q_query, q_adj, rn_in, rn_match, tx_busy,
    output inv_state, tx_start, tx_sel, resp_cmd, rn16, slot, q_cur, cmd_drop
  );
endinterface
`default_nettype wire

// File: rtl/tag_inv_ctrl_slot_ctr.sv
`default_nettype none
// ============================================================================
// inv_slot_ctr : Gen2 slot counter with Q-masked load and wrapping decrement
// Rev 1.0
// ============================================================================
module inv_slot_ctr
  import tag_inv_pkg::*;
#(
  parameter int SLOT_W = 15
) (
  input  wire               clk,
  input  wire               reset,
  input  wire slot_op_e     op,
  input  wire [3:0]         q,
  input  wire [15:0]        rn,
  output logic [SLOT_W-1:0] slot,
  output logic              next_zero
);

  logic [SLOT_W-1:0] slot_q, slot_d, load_val;

  always_comb begin
    load_val = SLOT_W'(32'(rn) & ((32'd1 << q) - 32'd1));
    slot_d   = slot_q;
    case (op)
      SLOT_LOAD: slot_d = load_val;
      // decrementing from zero wraps to all-ones, which is the Gen2 rule
      SLOT_DEC:  slot_d = slot_q - SLOT_W'(1);
      SLOT_MAX:  slot_d = '1;
      SLOT_CLR:  slot_d = '0;
      default:   slot_d = slot_q;
    endcase
    next_zero = (slot_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot = slot_q;

endmodule
`default_nettype wire

// File: rtl/tag_inv_ctrl.sv
`default_nettype none
// ============================================================================
// tag_inv_ctrl : Gen2 tag inventory/access FSM, RN16/handle and reply requests
// Rev 1.0
// ============================================================================
module tag_inv_ctrl
  import tag_inv_pkg::*;
#(
  parameter int         CMD_W   = 13,
  parameter int         SLOT_W  = 15,
  parameter logic [3:0] Q_RESET = 4'd4
) (
  input wire            clk,
  input wire            reset,
  tag_inv_ctrl_if.slave bus
);

  inv_state_e        state_q, state_d;
  tx_sel_e           tx_sel_q, tx_sel_d;
  logic              tx_start_q, tx_start_d;
  logic              cmd_drop_q, cmd_drop_d;
  logic [CMD_W-1:0]  resp_cmd_q, resp_cmd_d;
  logic [15:0]       rn16_q, rn16_d;
  logic [15:0]       handle_q, handle_d;
  logic [3:0]        q_q, q_d, q_load;
  logic              pd_q;
  slot_op_e          slot_op;
  logic              slot_next_zero;
  logic [SLOT_W-1:0] slot;

  logic ev, crc_fail, cmd_ok, accept;
  logic is_qrep, is_ack, is_query, is_qadj, is_sel, is_nack, is_reqrn, is_access, load_cmd;

  assign is_qrep   = bus.cmd_in[C_CMD_QUERYREP];
  assign is_ack    = bus.cmd_in[C_CMD_ACK];
  assign is_query  = bus.cmd_in[C_CMD_QUERY];
  assign is_qadj   = bus.cmd_in[C_CMD_QUERYADJ];
  assign is_sel    = bus.cmd_in[C_CMD_SELECT];
  assign is_nack   = bus.cmd_in[C_CMD_NACK];
  assign is_reqrn  = bus.cmd_in[C_CMD_REQRN];
  assign is_access = |bus.cmd_in[CMD_W-1:C_CMD_READ];

  assign ev       = bus.packet_done & ~pd_q;
  assign crc_fail = (is_query & bus.crc5_bad) |
                    ((is_sel | is_reqrn | bus.cmd_in[C_CMD_READ] | bus.cmd_in[C_CMD_WRITE] |
                      bus.cmd_in[C_CMD_CUSTOM11]) & bus.crc16_bad);
  assign cmd_ok   = ev & $onehot(bus.cmd_in) & ~crc_fail;
  // Select still applies while the tx path is busy; everything else is dropped
  assign accept   = cmd_ok & (~bus.tx_busy | is_sel);
  assign load_cmd = is_query | (is_qadj & (state_q != ST_READY));
  assign q_load   = is_query ? bus.q_query : q_adjust(q_q, bus.q_adj);

  // Slot op is decided apart from the FSM so the counter's next_zero can feed it back
  always_comb begin
    slot_op = SLOT_HOLD;
    if (accept) begin
      if (is_sel)                                     slot_op = SLOT_CLR;
      else if (load_cmd)                              slot_op = SLOT_LOAD;
      else if (is_qrep && state_q == ST_ARB)          slot_op = SLOT_DEC;
      else if (is_qrep && state_q != ST_READY)        slot_op = SLOT_MAX;
    end
  end

  inv_slot_ctr #(.SLOT_W(SLOT_W)) u_slot_ctr (
    .clk       (clk),
    .reset     (reset),
    .op        (slot_op),
    .q         (q_load),
    .rn        (bus.rn_in),
    .slot      (slot),
    .next_zero (slot_next_zero)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_sel_d   = tx_sel_q;
    resp_cmd_d = resp_cmd_q;
    rn16_d     = rn16_q;
    handle_d   = handle_q;
    q_d        = q_q;
    cmd_drop_d = cmd_ok & ~accept;
    if (accept) begin
      if (is_sel) begin
        state_d = ST_READY;
        q_d     = Q_RESET;
      end else if (load_cmd) begin
        q_d    = q_load;
        rn16_d = bus.rn_in;
        if (slot_next_zero) begin
          state_d    = ST_REPLY;
          tx_start_d = 1'b1;
          tx_sel_d   = TX_RN16;
        end else begin
          state_d = ST_ARB;
        end
      end else if (is_qrep) begin
        if (state_q == ST_ARB) begin
          if (slot_next_zero) begin
            state_d    = ST_REPLY;
            rn16_d     = bus.rn_in;
            tx_start_d = 1'b1;
            tx_sel_d   = TX_RN16;
          end
        end else if (state_q != ST_READY) begin
          state_d = ST_ARB;
        end
      end else if (is_ack) begin
        if (state_q == ST_REPLY || state_q == ST_ACK) begin
          if (bus.rn_match) begin
            state_d    = ST_ACK;
            tx_start_d = 1'b1;
            tx_sel_d   = TX_EPC;
          end else begin
            state_d = ST_ARB;
          end
        end
      end else if (is_nack) begin
        if (state_q != ST_READY) state_d = ST_ARB;
      end else if (is_reqrn) begin
        if (bus.rn_match && state_q == ST_ACK) begin
          state_d    = ST_OPEN;
          rn16_d     = bus.rn_in;
          handle_d   = bus.rn_in;
          tx_start_d = 1'b1;
          tx_sel_d   = TX_HANDLE;
        end else if (bus.rn_match && state_q == ST_OPEN) begin
          rn16_d     = bus.rn_in;
          tx_start_d = 1'b1;
          tx_sel_d   = TX_RN16;
        end
      end else if (is_access && bus.rn_match && state_q == ST_OPEN) begin
        resp_cmd_d = bus.cmd_in;
        tx_start_d = 1'b1;
        tx_sel_d   = TX_CMDRESP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_READY;
      tx_start_q <= 1'b0;
      tx_sel_q   <= TX_NONE;
      resp_cmd_q <= '0;
      rn16_q     <= '0;
      handle_q   <= '0;
      q_q        <= Q_RESET;
      cmd_drop_q <= 1'b0;
      pd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_sel_q   <= tx_sel_d;
      resp_cmd_q <= resp_cmd_d;
      rn16_q     <= rn16_d;
      handle_q   <= handle_d;
      q_q        <= q_d;
      cmd_drop_q <= cmd_drop_d;
      pd_q       <= bus.packet_done;
    end
  end

  assign bus.inv_state = state_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_sel    = tx_sel_q;
  assign bus.resp_cmd  = resp_cmd_q;
  assign bus.rn16      = rn16_q;
  assign bus.slot      = slot;
  assign bus.q_cur     = q_q;
  assign bus.cmd_drop  = cmd_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_inv_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tag_inv_ctrl : directed and randomized checks of tag_inv_ctrl against a rule-level model
// Rev 1.0
// ============================================================================
module tb_tag_inv_ctrl;

  localparam int CMD_W  = 13;
  localparam int SLOT_W = 15;
  localparam int SMAX   = (1 << SLOT_W) - 1;
  localparam int M_READY = 0, M_ARB = 1, M_REPLY = 2, M_ACK = 3, M_OPEN = 4;
  localparam logic [12:0] QREP = 13'h0001, ACK = 13'h0002, QUERY = 13'h0004, QADJ = 13'h0008;
  localparam logic [12:0] SEL = 13'h0010, NACK = 13'h0020, REQRN = 13'h0040, READ = 13'h0080;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tag_inv_ctrl_if #(.CMD_W(CMD_W), .SLOT_W(SLOT_W)) bus ();

  tag_inv_ctrl #(.CMD_W(CMD_W), .SLOT_W(SLOT_W), .Q_RESET(4'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: what the outputs must read just after the next rising edge
  int          m_state, m_slot, m_q, m_txsel;
  logic [15:0] m_rn16;
  logic [12:0] m_resp;
  bit          m_txstart, m_drop, m_pd_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = M_READY; m_slot = 0; m_q = 4; m_txsel = 0;
    m_rn16 = 16'h0; m_resp = 13'h0; m_txstart = 0; m_drop = 0; m_pd_prev = 0;
  endfunction

  function automatic void m_reply(input int sel);
    m_txstart = 1;
    m_txsel   = sel;
  endfunction

  function automatic void m_draw(input int q);
    m_q    = q;
    m_slot = int'(bus.rn_in) % (1 << q);
    m_rn16 = bus.rn_in;
    if (m_slot == 0) begin m_state = M_REPLY; m_reply(1); end
    else m_state = M_ARB;
  endfunction

  function automatic void model_step();
    bit ev;
    int c, nq;
    if (!reset) begin model_reset(); return; end
    ev = bus.packet_done && !m_pd_prev;
    m_pd_prev = bus.packet_done;
    m_txstart = 0;
    m_drop    = 0;
    if (!ev || $countones(bus.cmd_in) != 1) return;
    c = 0;
    for (int i = 0; i < CMD_W; i++) if (bus.cmd_in[i]) c = i;
    if (c == 2 && bus.crc5_bad) return;
    if ((c == 4 || c == 6 || c == 7 || c == 8 || c == 11) && bus.crc16_bad) return;
    if (bus.tx_busy && c != 4) begin m_drop = 1; return; end
    case (c)
      4: begin m_state = M_READY; m_q = 4; m_slot = 0; end
      2: m_draw(int'(bus.q_query));
      3: if (m_state != M_READY) begin
           nq = m_q + ((bus.q_adj == 2'b11) ? 1 : (bus.q_adj == 2'b01) ? -1 : 0);
           if (nq > 15) nq = 15;
           if (nq < 0)  nq = 0;
           m_draw(nq);
         end
      0: if (m_state == M_ARB) begin
           if (m_slot == 0) m_slot = SMAX;
           else begin
             m_slot = m_slot - 1;
             if (m_slot == 0) begin m_state = M_REPLY; m_rn16 = bus.rn_in; m_reply(1); end
           end
         end else if (m_state != M_READY) begin
           m_state = M_ARB; m_slot = SMAX;
         end
      1: if (m_state == M_REPLY || m_state == M_ACK) begin
           if (bus.rn_match) begin m_state = M_ACK; m_reply(2); end
           else m_state = M_ARB;
         end
      5: if (m_state != M_READY) m_state = M_ARB;
      6: if (bus.rn_match) begin
           if (m_state == M_ACK) begin m_state = M_OPEN; m_rn16 = bus.rn_in; m_reply(3); end
           else if (m_state == M_OPEN) begin m_rn16 = bus.rn_in; m_reply(1); end
         end
      default: if (m_state == M_OPEN && bus.rn_match) begin m_resp = bus.cmd_in; m_reply(4); end
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("inv_state", 32'(bus.inv_state), m_state);
      check("tx_start",  32'(bus.tx_start),  32'(m_txstart));
      check("tx_sel",    32'(bus.tx_sel),    m_txsel);
      check("resp_cmd",  32'(bus.resp_cmd),  32'(m_resp));
      check("rn16",      32'(bus.rn16),      32'(m_rn16));
      check("slot",      32'(bus.slot),      m_slot);
      check("q_cur",     32'(bus.q_cur),     m_q);
      check("cmd_drop",  32'(bus.cmd_drop),  32'(m_drop));
    end
  end

  // Inputs change only at the falling edge; the model is advanced at the same moment
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pkt(input logic [12:0] c, input bit match, input bit busy, input bit c5, input bit c16);
    if (bus.packet_done) begin
      bus.packet_done = 1'b0;
      tick();
    end
    bus.cmd_in = c; bus.rn_match = match; bus.tx_busy = busy;
    bus.crc5_bad = c5; bus.crc16_bad = c16; bus.packet_done = 1'b1;
    tick();
  endtask

  initial begin
    bus.cmd_in = '0; bus.packet_done = 0; bus.crc5_bad = 0; bus.crc16_bad = 0;
    bus.q_query = 0; bus.q_adj = 0; bus.rn_in = 0; bus.rn_match = 0; bus.tx_busy = 0;
    model_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst state", 32'(bus.inv_state), 0);
    check("rst q_cur", 32'(bus.q_cur), 4);
    check("rst slot",  32'(bus.slot), 0);
    check("rst tx",    {bus.tx_start, bus.tx_sel, bus.cmd_drop}, 0);
    chk_en = 1'b1;
    reset  = 1'b1;

    bus.rn_in = 16'hA5A5; bus.q_query = 4'd0;
    pkt(QUERY, 0, 0, 0, 0);
    check("q0 state", 32'(bus.inv_state), 2);
    check("q0 tx_start", 32'(bus.tx_start), 1);
    check("q0 tx_sel", 32'(bus.tx_sel), 1);
    check("q0 rn16", 32'(bus.rn16), 32'h0000A5A5);
    pkt(NACK, 0, 0, 0, 0);
    pkt(QREP, 0, 0, 0, 0);
    check("wrap slot", 32'(bus.slot), 32'h7FFF);
    check("wrap state", 32'(bus.inv_state), 1);

    bus.rn_in = 16'h0003; bus.q_query = 4'd2;
    pkt(QUERY, 0, 0, 0, 0);
    check("q2 slot", 32'(bus.slot), 3);
    check("q2 state", 32'(bus.inv_state), 1);
    pkt(QREP, 0, 0, 0, 0);
    check("qrep1 slot", 32'(bus.slot), 2);
    pkt(QREP, 0, 0, 0, 0);
    check("qrep2 slot", 32'(bus.slot), 1);
    bus.rn_in = 16'h1234;
    pkt(QREP, 0, 0, 0, 0);
    check("qrep3 state", 32'(bus.inv_state), 2);
    check("qrep3 tx", {bus.tx_start, bus.tx_sel}, 4'b1001);
    check("qrep3 rn16", 32'(bus.rn16), 32'h1234);

    pkt(ACK, 1, 0, 0, 0);
    check("ack state", 32'(bus.inv_state), 3);
    check("ack tx_sel", 32'(bus.tx_sel), 2);
    bus.rn_in = 16'hBEEF;
    pkt(REQRN, 1, 0, 0, 0);
    check("reqrn state", 32'(bus.inv_state), 4);
    check("reqrn tx_sel", 32'(bus.tx_sel), 3);
    check("reqrn handle", 32'(bus.rn16), 32'hBEEF);
    pkt(READ, 1, 0, 0, 0);
    check("read tx_sel", 32'(bus.tx_sel), 4);
    check("read resp_cmd", 32'(bus.resp_cmd), 32'h0080);
    bus.rn_in = 16'h0000; bus.q_query = 4'd0;
    pkt(QUERY, 0, 0, 1, 0);
    check("crc5 state", 32'(bus.inv_state), 4);
    check("crc5 tx_start", 32'(bus.tx_start), 0);
    pkt(READ, 1, 1, 0, 0);
    check("busy drop", 32'(bus.cmd_drop), 1);
    check("busy state", 32'(bus.inv_state), 4);

    bus.rn_in = 16'h8001; bus.q_query = 4'd15;
    pkt(QUERY, 0, 0, 0, 0);
    check("q15 slot", 32'(bus.slot), 1);
    bus.q_adj = 2'b11;
    pkt(QADJ, 0, 0, 0, 0);
    check("qadj up sat", 32'(bus.q_cur), 15);
    bus.q_query = 4'd0;
    pkt(QUERY, 0, 0, 0, 0);
    bus.q_adj = 2'b01;
    pkt(QADJ, 0, 0, 0, 0);
    check("qadj dn sat", 32'(bus.q_cur), 0);
    pkt(SEL, 0, 1, 0, 0);
    check("sel state", 32'(bus.inv_state), 0);
    check("sel q", 32'(bus.q_cur), 4);
    check("sel no drop", 32'(bus.cmd_drop), 0);

    bus.rn_in = 16'h0005;
    pkt(QUERY, 0, 0, 0, 0);
    pkt(ACK, 1, 0, 0, 0);
    pkt(REQRN, 1, 0, 0, 0);
    check("open again", 32'(bus.inv_state), 4);
    #2 reset = 1'b0;
    model_reset();
    bus.packet_done = 1'b0;
    #1;
    check("async state", 32'(bus.inv_state), 0);
    check("async rn16", 32'(bus.rn16), 0);
    check("async q", 32'(bus.q_cur), 4);
    check("async tx", {bus.tx_start, bus.tx_sel}, 0);
    repeat (2) tick();
    reset = 1'b1;

    for (int n = 0; n < 600; n++) begin
      int k;
      logic [12:0] c;
      k = $urandom_range(0, 99);
      if (k < 20)      c = QUERY;
      else if (k < 36) c = QREP;
      else if (k < 50) c = ACK;
      else if (k < 60) c = REQRN;
      else if (k < 70) c = 13'(1) << $urandom_range(7, 12);
      else if (k < 78) c = QADJ;
      else if (k < 84) c = NACK;
      else if (k < 88) c = SEL;
      else begin
        c = 13'(1) << $urandom_range(0, 12);
        c = c | (13'(1) << $urandom_range(0, 12));
      end
      bus.rn_in   = 16'($urandom);
      bus.q_query = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      bus.q_adj   = 2'($urandom_range(0, 3));
      pkt(c, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) begin
        bus.rn_in   = 16'($urandom);
        bus.tx_busy = 1'($urandom_range(0, 1));
        tick();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
